// File: rtl/cpu_alu_seq.sv
// cpu_alu_seq: multi-cycle ALU sequencer on the shared 8-bit register-file bus.
// Reads one or two source registers, computes an 8-bit result with {N,C,Z}
// flags and writes the result back to a destination register.
// Optional feature macro: CPU_ALU_SHIFT_EN enables SHL/SHR. When it is not
// defined, opcodes 110/111 are illegal and no shift logic is built.
module cpu_alu_seq (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [2:0] op,
  input  logic [2:0] ra,
  input  logic [2:0] rb,
  input  logic [2:0] rd,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [2:0] flags,
  output logic [2:0] reg_sel,
  output logic       reg_oe,
  output logic       reg_we,
  input  logic [7:0] bus_in,
  output logic [7:0] bus_out,
  output logic       bus_oe
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RD_A = 3'd1;
  localparam logic [2:0] S_RD_B = 3'd2;
  localparam logic [2:0] S_EXEC = 3'd3;
  localparam logic [2:0] S_WB   = 3'd4;
  localparam logic [2:0] S_FIN  = 3'd5;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_NOT = 3'b101;
  localparam logic [2:0] OP_SHL = 3'b110;
  localparam logic [2:0] OP_SHR = 3'b111;

  logic [2:0] state_q, state_d;
  logic [2:0] op_q, op_d;
  logic [2:0] ra_q, ra_d;
  logic [2:0] rb_q, rb_d;
  logic [2:0] rd_q, rd_d;
  logic [7:0] a_q, a_d;
  logic [7:0] b_q, b_d;
  logic [7:0] r_q, r_d;
  logic [2:0] flags_q, flags_d;
  logic       err_q, err_d;

  logic       op_legal;
  logic       op_unary;
  logic [7:0] alu_res;
  logic       alu_c;

  // Opcode classification: legality of the incoming op, arity of the latched op
  always_comb begin
`ifdef CPU_ALU_SHIFT_EN
    op_legal = 1'b1;
    op_unary = (op_q == OP_NOT) || (op_q == OP_SHL) || (op_q == OP_SHR);
`else
    op_legal = (op != OP_SHL) && (op != OP_SHR);
    op_unary = (op_q == OP_NOT);
`endif
  end

  // ALU: result and carry/borrow from latched operands
  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    case (op_q)
      OP_ADD: {alu_c, alu_res} = {1'b0, a_q} + {1'b0, b_q};
      OP_SUB: begin
        alu_res = a_q - b_q;
        alu_c   = (a_q < b_q);
      end
      OP_AND: alu_res = a_q & b_q;
      OP_OR:  alu_res = a_q | b_q;
      OP_XOR: alu_res = a_q ^ b_q;
      OP_NOT: alu_res = ~a_q;
`ifdef CPU_ALU_SHIFT_EN
      OP_SHL: begin
        alu_res = {a_q[6:0], 1'b0};
        alu_c   = a_q[7];
      end
      OP_SHR: begin
        alu_res = {1'b0, a_q[7:1]};
        alu_c   = a_q[0];
      end
`endif
      default: begin
        alu_res = '0;
        alu_c   = 1'b0;
      end
    endcase
  end

  // Sequencer next-state and datapath capture
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    ra_d    = ra_q;
    rb_d    = rb_q;
    rd_d    = rd_q;
    a_d     = a_q;
    b_d     = b_q;
    r_d     = r_q;
    flags_d = flags_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d    = op;
          ra_d    = ra;
          rb_d    = rb;
          rd_d    = rd;
          err_d   = ~op_legal;
          state_d = op_legal ? S_RD_A : S_FIN;
        end
      end
      S_RD_A: begin
        a_d     = bus_in;
        state_d = op_unary ? S_EXEC : S_RD_B;
      end
      S_RD_B: begin
        b_d     = bus_in;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        r_d     = alu_res;
        flags_d = {alu_res[7], alu_c, (alu_res == 8'h00)};
        state_d = S_WB;
      end
      S_WB:  state_d = S_FIN;
      S_FIN: begin
        err_d   = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      ra_q    <= '0;
      rb_q    <= '0;
      rd_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      r_q     <= '0;
      flags_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      rd_q    <= rd_d;
      a_q     <= a_d;
      b_q     <= b_d;
      r_q     <= r_d;
      flags_q <= flags_d;
      err_q   <= err_d;
    end
  end

  // Control outputs decoded from state; held at zero while rst is high so a
  // reset landing on WB suppresses the write in that same cycle
  always_comb begin
    busy    = 1'b0;
    done    = 1'b0;
    err     = 1'b0;
    reg_sel = '0;
    reg_oe  = 1'b0;
    reg_we  = 1'b0;
    bus_out = '0;
    bus_oe  = 1'b0;
    if (!rst) begin
      case (state_q)
        S_RD_A: begin
          busy    = 1'b1;
          reg_sel = ra_q;
          reg_oe  = 1'b1;
        end
        S_RD_B: begin
          busy    = 1'b1;
          reg_sel = rb_q;
          reg_oe  = 1'b1;
        end
        S_EXEC: busy = 1'b1;
        S_WB: begin
          busy    = 1'b1;
          reg_sel = rd_q;
          bus_oe  = 1'b1;
          bus_out = r_q;
          reg_we  = 1'b1;
        end
        S_FIN: begin
          done = 1'b1;
          err  = err_q;
        end
        default: ;
      endcase
    end
  end

  assign flags = flags_q;

endmodule

// File: tb/tb_cpu_alu_seq.sv
// Directed, table-driven bench for cpu_alu_seq with a behavioural register file.
module tb_cpu_alu_seq;

`ifdef CPU_ALU_SHIFT_EN
  localparam bit SHIFT_ON = 1'b1;
`else
  localparam bit SHIFT_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [2:0] op, ra, rb, rd;
  logic       busy, done, err;
  logic [2:0] flags;
  logic [2:0] reg_sel;
  logic       reg_oe, reg_we;
  logic [7:0] bus_in, bus_out;
  logic       bus_oe;

  logic [7:0] regs [8];
  logic [19:0] outs_all;

  int checks = 0;
  int failures = 0;
  int cyc;
  int we_total = 0;
  int done_total = 0;
  int conflict = 0;
  logic [2:0] model_flags;

  cpu_alu_seq dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .ra(ra), .rb(rb), .rd(rd),
    .busy(busy), .done(done), .err(err), .flags(flags), .reg_sel(reg_sel),
    .reg_oe(reg_oe), .reg_we(reg_we), .bus_in(bus_in), .bus_out(bus_out),
    .bus_oe(bus_oe)
  );

  always #5 clk = ~clk;

  assign bus_in   = reg_oe ? regs[reg_sel] : (bus_oe ? bus_out : 8'h00);
  assign outs_all = {busy, done, err, flags, reg_sel, reg_oe, reg_we, bus_out, bus_oe};

  always @(negedge clk) begin
    if (reg_we) we_total++;
    if (done) done_total++;
    if (reg_oe && bus_oe) conflict++;
  end

  typedef struct {
    logic [2:0] op;
    logic [2:0] ra;
    logic [2:0] rb;
    logic [2:0] rd;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] r;
    logic [2:0] fl;
    logic       unary;
    logic       legal;
  } vec_t;

  vec_t tbl [11];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock: commit a write seen this cycle into the register model, then
  // land 1 time unit after the rising edge where inputs are driven and sampled.
  task automatic tick();
    logic       we;
    logic [2:0] s;
    logic [7:0] v;
    we = reg_we;
    s  = reg_sel;
    v  = bus_out;
    @(posedge clk);
    #1;
    if (we) regs[s] = v;
    cyc++;
  endtask

  task automatic issue(input logic [2:0] o, input logic [2:0] a, input logic [2:0] b,
                       input logic [2:0] d);
    start = 1'b1;
    op = o;
    ra = a;
    rb = b;
    rd = d;
    cyc = 0;
  endtask

  task automatic run_row(input int i);
    int done_cyc, we_cyc, oe_cnt, busy_cnt, exp_done;
    logic err_v;
    logic [2:0] we_sel, fl_v;
    logic [7:0] we_val;
    done_cyc = 0; we_cyc = 0; oe_cnt = 0; busy_cnt = 0;
    err_v = 1'b0; we_sel = '0; we_val = '0; fl_v = '0;
    regs[tbl[i].ra] = tbl[i].a;
    regs[tbl[i].rb] = tbl[i].b;
    issue(tbl[i].op, tbl[i].ra, tbl[i].rb, tbl[i].rd);
    tick();
    start = 1'b0;
    while (cyc <= 15 && done_cyc == 0) begin
      if (reg_oe) oe_cnt++;
      if (busy) busy_cnt++;
      if (reg_we) begin
        we_cyc = cyc;
        we_val = bus_out;
        we_sel = reg_sel;
      end
      if (done) begin
        done_cyc = cyc;
        err_v = err;
        fl_v = flags;
      end else begin
        tick();
      end
    end
    tick();
    if (tbl[i].legal) model_flags = tbl[i].fl;
    exp_done = !tbl[i].legal ? 1 : (tbl[i].unary ? 4 : 5);
    chk($sformatf("row%0d done_cyc", i), done_cyc, exp_done);
    chk($sformatf("row%0d err", i), int'(err_v), int'(!tbl[i].legal));
    chk($sformatf("row%0d busy_cycles", i), busy_cnt, exp_done - 1);
    chk($sformatf("row%0d reg_oe_cycles", i), oe_cnt,
        !tbl[i].legal ? 0 : (tbl[i].unary ? 1 : 2));
    chk($sformatf("row%0d flags", i), int'(fl_v), int'(model_flags));
    chk($sformatf("row%0d we_cyc", i), we_cyc, tbl[i].legal ? exp_done - 1 : 0);
    if (tbl[i].legal) begin
      chk($sformatf("row%0d we_val", i), int'(we_val), int'(tbl[i].r));
      chk($sformatf("row%0d we_sel", i), int'(we_sel), int'(tbl[i].rd));
    end
  endtask

  initial begin
    int d0, w0;
    //            op      ra    rb    rd    a      b      r      fl      unary legal
    tbl[0]  = '{3'b000, 3'd1, 3'd2, 3'd3, 8'hF0, 8'h20, 8'h10, 3'b010, 1'b0, 1'b1};
    tbl[1]  = '{3'b001, 3'd4, 3'd4, 3'd4, 8'h05, 8'h05, 8'h00, 3'b001, 1'b0, 1'b1};
    tbl[2]  = '{3'b001, 3'd4, 3'd5, 3'd4, 8'h05, 8'h06, 8'hFF, 3'b110, 1'b0, 1'b1};
    tbl[3]  = '{3'b101, 3'd0, 3'd0, 3'd7, 8'h80, 8'h80, 8'h7F, 3'b000, 1'b1, 1'b1};
    tbl[4]  = '{3'b010, 3'd1, 3'd2, 3'd6, 8'hF0, 8'h3C, 8'h30, 3'b000, 1'b0, 1'b1};
    tbl[5]  = '{3'b011, 3'd1, 3'd2, 3'd6, 8'h00, 8'h00, 8'h00, 3'b001, 1'b0, 1'b1};
    tbl[6]  = '{3'b100, 3'd3, 3'd5, 3'd2, 8'hAA, 8'h55, 8'hFF, 3'b100, 1'b0, 1'b1};
    tbl[7]  = '{3'b000, 3'd1, 3'd2, 3'd3, 8'h80, 8'h80, 8'h00, 3'b011, 1'b0, 1'b1};
    tbl[8]  = '{3'b110, 3'd5, 3'd5, 3'd6, 8'h81, 8'h81, 8'h02, 3'b010, 1'b1, SHIFT_ON};
    tbl[9]  = '{3'b111, 3'd5, 3'd5, 3'd6, 8'h01, 8'h01, 8'h00, 3'b011, 1'b1, SHIFT_ON};
    tbl[10] = '{3'b111, 3'd5, 3'd5, 3'd6, 8'h80, 8'h80, 8'h40, 3'b000, 1'b1, SHIFT_ON};

    for (int i = 0; i < 8; i++) regs[i] = 8'h00;
    rst = 1'b1; start = 1'b0; op = '0; ra = '0; rb = '0; rd = '0;
    cyc = 0;
    model_flags = 3'b000;
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("reset_outputs", int'(outs_all), 0);

    for (int i = 0; i < 11; i++) run_row(i);

    // Reset held 2 cycles starting in RD_B: operation abandoned
    regs[1] = 8'hF0; regs[2] = 8'h20;
    d0 = done_total; w0 = we_total;
    issue(3'b000, 3'd1, 3'd2, 3'd3);
    tick(); start = 1'b0;
    tick();
    chk("rdb_state_oe", int'(reg_oe), 1);
    rst = 1'b1;
    #1;
    chk("rdb_rst_forced_outputs", int'({busy, reg_oe, reg_sel}), 0);
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("rdb_post_reset_outputs", int'(outs_all), 0);
    model_flags = 3'b000;
    repeat (8) tick();
    chk("rdb_no_done", done_total - d0, 0);
    chk("rdb_no_write", we_total - w0, 0);

    // Reset landing on WB suppresses the write
    d0 = done_total; w0 = we_total;
    issue(3'b000, 3'd1, 3'd2, 3'd3);
    tick(); start = 1'b0;
    repeat (3) tick();
    chk("wb_state_we", int'(reg_we), 1);
    rst = 1'b1;
    #1;
    chk("wb_rst_we_forced", int'({reg_we, bus_oe, bus_out}), 0);
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("wb_post_reset_outputs", int'(outs_all), 0);
    repeat (8) tick();
    chk("wb_no_done", done_total - d0, 0);
    chk("wb_no_write", we_total - w0, 0);

    // start held high through two full binary operations
    regs[1] = 8'hF0; regs[2] = 8'h20;
    d0 = done_total; w0 = we_total;
    issue(3'b000, 3'd1, 3'd2, 3'd3);
    repeat (12) tick();
    start = 1'b0;
    repeat (8) tick();
    chk("hold_done_count", done_total - d0, 2);
    chk("hold_write_count", we_total - w0, 2);

    // start pulsed while busy is ignored
    d0 = done_total; w0 = we_total;
    issue(3'b000, 3'd1, 3'd2, 3'd3);
    tick(); start = 1'b0;
    tick();
    start = 1'b1; op = 3'b101; ra = 3'd0; rb = 3'd0; rd = 3'd7;
    tick();
    start = 1'b0;
    repeat (10) tick();
    chk("pulse_done_count", done_total - d0, 1);
    chk("pulse_write_count", we_total - w0, 1);

    chk("oe_conflict", conflict, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
